regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Bus-side initiator for the 8-bit, 16-entry register file.
- On command, it streams a contiguous register range out of the file (DUMP) or streams data into it (LOAD). Both directions use valid/ready handshakes.
- Drives the file's read-address input (srcA side) and its write triple (WriteReg, RegWriteCtrl, WriteData). Used for debug dump, state save/restore and boot-time initialisation.

Parameters:
- dataSize, 8, register data width
- numReg, 4, address width; the file holds 2**numReg entries

Ports:
- CLK  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle command strobe; honoured only when Busy=0
- Mode  in  1  sampled at Start: 0=DUMP, 1=LOAD
- StartAddr  in  numReg  first register index, sampled at Start
- Count  in  numReg+1  number of registers to transfer, sampled at Start; range 0..2**numReg
- Busy  out  1  high while a command is in progress
- Done  out  1  one-cycle pulse when a command completes
- RdAddr  out  numReg  read address to the register file
- RdData  in  dataSize  combinational read data returned for RdAddr
- WrAddr  out  numReg  write address to the register file
- WrEn  out  1  write enable to the register file
- WrData  out  dataSize  write data to the register file
- InValid  in  1  LOAD stream: data valid
- InReady  out  1  LOAD stream: sequencer ready
- InData  in  dataSize  LOAD stream data
- OutValid  out  1  DUMP stream: data valid
- OutReady  in  1  DUMP stream: consumer ready
- OutData  out  dataSize  DUMP stream data

Behaviour:
- Reset (synchronous, active-high) forces: state=IDLE; Busy, Done, OutValid, InReady, WrEn = 0; RdAddr, WrAddr, WrData, OutData = 0; index and remaining counters = 0.
- Reset mid-command abandons the command: no Done pulse, no further writes.
- States: IDLE, DUMP, DRAIN, LOAD.
- IDLE, on Start:
  - Count=0: Done pulses the next cycle; state stays IDLE; Busy stays 0.
  - Otherwise: latch idx=StartAddr and rem=Count, set Busy=1, go to DUMP (Mode=0) or LOAD (Mode=1).
- Start while Busy=1 is ignored.
- Addressing: idx increments modulo 2**numReg. StartAddr=14 with Count=4 visits 14, 15, 0, 1.
- DUMP:
  - RdAddr=idx, driven combinationally from the idx register.
  - The output buffer is free when OutValid=0, or when OutValid=1 and OutReady=1.
  - When free: OutData<=RdData, OutValid<=1, idx++, rem--.
  - When the last element is captured (rem goes 1->0), go to DRAIN.
  - OutData is held stable while OutValid=1 and OutReady=0.
  - Sustained throughput with OutReady held high is one element per cycle.
- DRAIN:
  - On OutValid and OutReady: OutValid<=0, Done<=1, Busy<=0, go to IDLE.
  - Done therefore asserts the cycle after the final accept.
- LOAD:
  - InReady=1, registered: it rises the cycle after Start.
  - WrAddr=idx, WrData=InData, WrEn=InValid&InReady, all combinational. The file write lands on the same edge as the handshake.
  - On each handshake: idx++, rem--.
  - When rem goes 1->0: InReady<=0, Done<=1, Busy<=0, go to IDLE. No write occurs after the last handshake.
- In DUMP and DRAIN, WrEn=0 always. In LOAD, OutValid=0 always.
- Done and Start in the same cycle: the Start is accepted, because Busy is already 0 when Done is high.
- A DUMP of a register written by a preceding LOAD returns the new value: the file's read path is combinational, so no hazard exists.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_SIZE=8 and NUM_REG=4;
  - typedef enum logic [1:0] seq_state_t {IDLE, DUMP, DRAIN, LOAD};
  - typedefs reg_addr_t and reg_data_t.
- Sub-module regfile_out_buf: a single-entry valid/ready holding register for the DUMP stream, with a capture-when-free rule. Keeps the FSM free of stream back-pressure logic.

Test Plan:
- LOAD StartAddr=0, Count=16, InData=0xA0+i, InValid held high -> 16 consecutive WrEn cycles at WrAddr 0..15; Done one cycle after the last write; the file holds 0xA0..0xAF.
- DUMP StartAddr=0, Count=16, OutReady held high -> OutData 0xA0..0xAF on 16 consecutive cycles; Done pulses the cycle after the final accept.
- DUMP StartAddr=14, Count=4, OutReady toggling 1,0,0,1,... -> order 0xAE, 0xAF, 0xA0, 0xA1; OutData stable while stalled; no element lost or duplicated.
- Count=0 in either mode -> Done pulses the next cycle; Busy, WrEn and OutValid stay 0.
- Start asserted mid-LOAD, then Reset asserted after 3 writes -> the mid-LOAD Start is ignored; only registers 0..2 change; after Reset all outputs are 0 and no Done pulse occurs.
- LOAD StartAddr=15, Count=2 with InValid gaps -> writes land only at 15 then 0; WrEn=0 during gaps.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file sequencer and its stream buffer.
package regfile_pkg;

    localparam int DATA_SIZE = 8;
    localparam int NUM_REG   = 4;

    typedef enum logic [1:0] {IDLE, DUMP, DRAIN, LOAD} seq_state_t;

    typedef logic [NUM_REG-1:0]   reg_addr_t;
    typedef logic [DATA_SIZE-1:0] reg_data_t;

endpackage

// File: rtl/regfile_out_buf.sv
// Single-entry valid/ready holding register for the DUMP stream.
// Captures new data only when the slot is empty or being drained this cycle.
module regfile_out_buf #(
    parameter int dataSize = 8
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                cap_req,
    input  logic [dataSize-1:0] cap_data,
    input  logic                OutReady,
    output logic                free,
    output logic                OutValid,
    output logic [dataSize-1:0] OutData
);

    logic                valid_q, valid_d;
    logic [dataSize-1:0] data_q, data_d;

    always_comb begin
        free    = !valid_q || OutReady;
        valid_d = valid_q;
        data_d  = data_q;
        if (cap_req && free) begin
            valid_d = 1'b1;
            data_d  = cap_data;
        end else if (valid_q && OutReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign OutValid = valid_q;
    assign OutData  = data_q;

endmodule

// File: rtl/regfile_sequencer.sv
// Bus-side initiator that dumps a register range to a stream or loads one from
// a stream, addressing the register file with a wrapping index.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int dataSize = DATA_SIZE,
    parameter int numReg   = NUM_REG
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Mode,
    input  logic [numReg-1:0]   StartAddr,
    input  logic [numReg:0]     Count,
    output logic                Busy,
    output logic                Done,
    output logic [numReg-1:0]   RdAddr,
    input  logic [dataSize-1:0] RdData,
    output logic [numReg-1:0]   WrAddr,
    output logic                WrEn,
    output logic [dataSize-1:0] WrData,
    input  logic                InValid,
    output logic                InReady,
    input  logic [dataSize-1:0] InData,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [dataSize-1:0] OutData
);

    localparam logic [numReg:0] REM_ONE = 1;

    seq_state_t        state_q, state_d;
    logic [numReg-1:0] idx_q, idx_d;
    logic [numReg:0]   rem_q, rem_d;
    logic              done_q, done_d;
    logic              in_ready_q, in_ready_d;
    logic              buf_free;
    logic              cap_req;

    regfile_out_buf #(.dataSize(dataSize)) u_out_buf (
        .CLK      (CLK),
        .Reset    (Reset),
        .cap_req  (cap_req),
        .cap_data (RdData),
        .OutReady (OutReady),
        .free     (buf_free),
        .OutValid (OutValid),
        .OutData  (OutData)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        in_ready_d = in_ready_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d      = StartAddr;
                        rem_d      = Count;
                        state_d    = Mode ? LOAD : DUMP;
                        in_ready_d = Mode;
                    end
                end
            end
            DUMP: begin
                // The buffer decides when a capture happens; the index follows it.
                if (buf_free) begin
                    idx_d = idx_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == REM_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (OutValid && OutReady) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (InValid && in_ready_q) begin
                    idx_d = idx_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == REM_ONE) begin
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        RdAddr  = idx_q;
        cap_req = (state_q == DUMP);
        Busy    = (state_q != IDLE);
        Done    = done_q;
        InReady = in_ready_q;
        WrAddr  = '0;
        WrData  = '0;
        WrEn    = 1'b0;
        if (state_q == LOAD) begin
            WrAddr = idx_q;
            WrData = InData;
            // A reset on this edge abandons the command, so the pending write is dropped too.
            WrEn   = InValid && in_ready_q && !Reset;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 16x8 register file attached.
module tb_regfile_sequencer;

    logic       CLK = 1'b0;
    logic       Reset, Start, Mode;
    logic [3:0] StartAddr;
    logic [4:0] Count;
    logic       Busy, Done, WrEn, InValid, InReady, OutValid, OutReady;
    logic [3:0] RdAddr, WrAddr;
    logic [7:0] RdData, WrData, InData, OutData;

    logic [7:0] rf  [16];
    logic [7:0] mdl [16];

    int total = 0;
    int bad   = 0;

    regfile_sequencer dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Mode(Mode),
        .StartAddr(StartAddr), .Count(Count), .Busy(Busy), .Done(Done),
        .RdAddr(RdAddr), .RdData(RdData), .WrAddr(WrAddr), .WrEn(WrEn),
        .WrData(WrData), .InValid(InValid), .InReady(InReady), .InData(InData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (WrEn) rf[WrAddr] <= WrData;
    assign RdData = rf[RdAddr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       mode;
        logic [3:0] saddr;
        logic [4:0] cnt;
        logic [7:0] base;
    } cmd_t;

    task automatic run_load(input logic [3:0] s, input logic [4:0] c, input logic [7:0] b);
        logic [3:0] a;
        @(negedge CLK);
        Start = 1; Mode = 1; StartAddr = s; Count = c; InValid = 0;
        #1 chk("load_busy_before", Busy, 0);
        for (int i = 0; i < c; i++) begin
            @(negedge CLK);
            Start = 0; InValid = 1; InData = b + 8'(i);
            a = s + 4'(i);
            #1;
            chk("load_wren", WrEn, 1);
            chk("load_wraddr", WrAddr, a);
            chk("load_wrdata", WrData, b + 8'(i));
            mdl[a] = b + 8'(i);
        end
        @(negedge CLK);
        InValid = 0;
        #1;
        chk("load_done", Done, 1);
        chk("load_busy_after", Busy, 0);
        chk("load_inready_after", InReady, 0);
    endtask

    task automatic run_dump(input logic [3:0] s, input logic [4:0] c);
        logic [3:0] a;
        @(negedge CLK);
        Start = 1; Mode = 0; StartAddr = s; Count = c; OutReady = 1;
        #1 chk("dump_busy_before", Busy, 0);
        @(negedge CLK);
        Start = 0;
        #1;
        chk("dump_first_valid", OutValid, 0);
        chk("dump_rdaddr", RdAddr, s);
        for (int i = 0; i < c; i++) begin
            @(negedge CLK);
            a = s + 4'(i);
            #1;
            chk("dump_valid", OutValid, 1);
            chk("dump_data", OutData, mdl[a]);
            chk("dump_wren", WrEn, 0);
        end
        @(negedge CLK);
        #1;
        chk("dump_done", Done, 1);
        chk("dump_valid_after", OutValid, 0);
        chk("dump_busy_after", Busy, 0);
    endtask

    cmd_t tbl [6];

    initial begin
        logic [7:0] ex [4];
        int         n, last_acc;
        logic       done_seen, held_v;
        logic [7:0] held;

        tbl[0] = '{1'b1, 4'd0, 5'd16, 8'hA0};
        tbl[1] = '{1'b0, 4'd0, 5'd16, 8'h00};
        tbl[2] = '{1'b1, 4'd5, 5'd3,  8'h10};
        tbl[3] = '{1'b0, 4'd4, 5'd5,  8'h00};
        tbl[4] = '{1'b1, 4'd8, 5'd2,  8'h30};
        tbl[5] = '{1'b0, 4'd6, 5'd4,  8'h00};
        ex[0] = 8'hAE; ex[1] = 8'hAF; ex[2] = 8'hA0; ex[3] = 8'hA1;

        Reset = 1; Start = 0; Mode = 0; StartAddr = 0; Count = 0;
        InValid = 0; InData = 0; OutReady = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_outs", {OutValid, InReady, WrEn}, 0);
        chk("rst_addrs", {RdAddr, WrAddr}, 0);
        chk("rst_data", {WrData, OutData}, 0);
        Reset = 0;

        for (int t = 0; t < 6; t++) begin
            if (tbl[t].mode) run_load(tbl[t].saddr, tbl[t].cnt, tbl[t].base);
            else             run_dump(tbl[t].saddr, tbl[t].cnt);
        end
        for (int i = 0; i < 16; i++) chk("file_contents", rf[i], mdl[i]);

        // Wrapped dump with OutReady pattern 1,0,0,1,0,0,...
        @(negedge CLK);
        Start = 1; Mode = 0; StartAddr = 14; Count = 4; OutReady = 0;
        n = 0; last_acc = -10; done_seen = 0; held_v = 0; held = 0;
        for (int k = 0; k < 40 && !done_seen; k++) begin
            @(negedge CLK);
            Start = 0; OutReady = (k % 3 == 0);
            #1;
            chk("stall_wren", WrEn, 0);
            if (held_v) begin
                chk("stall_hold_valid", OutValid, 1);
                chk("stall_hold_data", OutData, held);
            end
            if (Done) begin
                chk("stall_done_timing", k, last_acc + 1);
                done_seen = 1;
            end
            if (OutValid && OutReady) begin
                if (n < 4) chk("stall_order", OutData, ex[n]);
                n++;
                last_acc = k;
            end
            held_v = OutValid && !OutReady;
            held   = OutData;
        end
        chk("stall_count", n, 4);
        chk("stall_done_seen", done_seen, 1);

        // Count = 0 in both modes
        for (int m = 0; m < 2; m++) begin
            @(negedge CLK);
            Start = 1; Mode = m[0]; StartAddr = 3; Count = 0; InValid = 1; OutReady = 1;
            #1 chk("zero_busy_start", Busy, 0);
            @(negedge CLK);
            Start = 0;
            #1;
            chk("zero_done", Done, 1);
            chk("zero_busy", Busy, 0);
            chk("zero_outs", {WrEn, OutValid, InReady}, 0);
            @(negedge CLK);
            #1 chk("zero_done_once", Done, 0);
        end
        InValid = 0;

        // Mid-LOAD Start is ignored; Reset after three writes abandons the command
        @(negedge CLK);
        Start = 1; Mode = 1; StartAddr = 0; Count = 8; InValid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            Start = (i == 1); Mode = 0; StartAddr = 9; Count = 1;
            InValid = 1; InData = 8'h50 + 8'(i);
            #1;
            chk("midload_wren", WrEn, 1);
            chk("midload_wraddr", WrAddr, i);
            chk("midload_busy", Busy, 1);
        end
        @(negedge CLK);
        Start = 0; Reset = 1; InData = 8'h53;
        #1 chk("midload_wren_in_reset", WrEn, 0);
        @(negedge CLK);
        Reset = 0; InValid = 0;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_ctrl", {OutValid, InReady, WrEn}, 0);
        chk("abort_addrs", {RdAddr, WrAddr}, 0);
        chk("abort_data", {WrData, OutData}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1 chk("abort_no_done", Done, 0);
        end
        for (int i = 0; i < 3; i++) mdl[i] = 8'h50 + 8'(i);
        for (int i = 0; i < 5; i++) chk("abort_file", rf[i], mdl[i]);

        // Wrapped LOAD with InValid gaps, then a DUMP started on the Done cycle
        @(negedge CLK);
        Start = 1; Mode = 1; StartAddr = 15; Count = 2; InValid = 0;
        @(negedge CLK);
        Start = 0;
        #1;
        chk("gap_inready", InReady, 1);
        chk("gap_wren0", WrEn, 0);
        @(negedge CLK);
        InValid = 1; InData = 8'hC0;
        #1;
        chk("gap_wr1_en", WrEn, 1);
        chk("gap_wr1_addr", WrAddr, 15);
        @(negedge CLK);
        InValid = 0;
        #1 chk("gap_wren1", WrEn, 0);
        @(negedge CLK);
        InValid = 1; InData = 8'hC1;
        #1;
        chk("gap_wr2_en", WrEn, 1);
        chk("gap_wr2_addr", WrAddr, 0);
        chk("gap_wr2_data", WrData, 8'hC1);
        @(negedge CLK);
        InValid = 0; Start = 1; Mode = 0; StartAddr = 15; Count = 2; OutReady = 1;
        #1;
        chk("gap_done", Done, 1);
        chk("gap_busy", Busy, 0);
        @(negedge CLK);
        Start = 0;
        #1;
        chk("back2back_busy", Busy, 1);
        chk("back2back_done_once", Done, 0);
        chk("back2back_rdaddr", RdAddr, 15);
        @(negedge CLK);
        #1 chk("readback_0", {OutValid, OutData}, {1'b1, 8'hC0});
        @(negedge CLK);
        #1 chk("readback_1", {OutValid, OutData}, {1'b1, 8'hC1});
        @(negedge CLK);
        #1 chk("readback_done", Done, 1);
        chk("gap_file_1", rf[1], 8'h51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
